adau1761_spi_responder: RTL and testbench

ADAU1761_SPI_RESPONDER -- requirements
Module: adau1761_spi_responder

---
 rtl/adau1761_spi_responder.sv | 183 ++++++++++++++++++
 tb/tb_adau1761_spi_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adau1761_spi_responder.sv
// SPI-mode register-map emulation of an ADAU1761 codec: three cs toggles latch SPI mode, then
// frames of cmd / addr_hi / addr_lo / data... read or write a 256-byte window starting at BASE_ADDR.
module adau1761_spi_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'h4000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sclk,
    input  logic       cs,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic       spi_mode,
    output logic       wr_stb,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR_HI, ADDR_LO, DATA} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync, fill;
    logic       sclk_s, cs_s, sdi_s, filled;
    logic       sclk_prev, cs_prev, armed;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic       bit_sample, byte_done, we, in_range, load;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] byte_val, tx, rd_val;
    logic [15:0] addr, off;
    logic       is_read;
    logic [1:0] cs_cnt;
    logic [7:0] mem [256];

    // fill marks when the chains hold real samples rather than reset values
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            sdi_sync  <= '0;
            fill      <= '0;
        end else begin
            sclk_sync <= SYNC_STAGES'({sclk_sync, sclk});
            cs_sync   <= SYNC_STAGES'({cs_sync, cs});
            sdi_sync  <= SYNC_STAGES'({sdi_sync, sdi});
            fill      <= SYNC_STAGES'({fill, 1'b1});
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];
    assign filled = fill[SYNC_STAGES-1];

    assign sclk_rise = filled & sclk_s & ~sclk_prev;
    assign sclk_fall = filled & ~sclk_s & sclk_prev;
    assign cs_rise   = filled & cs_s & ~cs_prev;
    // a frame only starts after cs has been seen high, so a frame cut by reset is not resumed
    assign cs_fall   = filled & ~cs_s & cs_prev & armed;

    assign bit_sample = sclk_rise & ~cs_s & (state != IDLE);
    assign byte_val   = {shreg, sdi_s};
    assign byte_done  = bit_sample & (bit_cnt == 3'd7);

    assign off      = addr - BASE_ADDR;
    assign in_range = (off[15:8] == 8'h00);
    assign rd_val   = in_range ? mem[off[7:0]] : 8'h00;
    assign we       = byte_done & (state == DATA) & ~is_read & spi_mode & in_range;

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        sdo_oe     = 1'b0;
        sdo        = 1'b0;
        if (cs_rise) begin
            state_next = IDLE;
        end else if (cs_fall) begin
            state_next = CMD;
        end else if (byte_done) begin
            unique case (state)
                CMD:     state_next = ADDR_HI;
                ADDR_HI: state_next = ADDR_LO;
                ADDR_LO: state_next = DATA;
                DATA:    state_next = DATA;
                default: state_next = IDLE;
            endcase
        end
        if (spi_mode && is_read && state == DATA && !cs_s) begin
            sdo_oe = 1'b1;
            sdo    = tx[7];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            is_read   <= 1'b0;
            addr      <= '0;
            tx        <= '0;
            load      <= 1'b0;
            cs_cnt    <= '0;
            spi_mode  <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            armed     <= armed | (filled & cs_s);
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            load      <= 1'b0;

            if (cs_rise) begin
                bit_cnt <= '0;
                if (spi_mode && state != IDLE && bit_cnt != 3'd0)
                    frame_err <= 1'b1;
                if (!spi_mode) begin
                    if (cs_cnt == 2'd2) spi_mode <= 1'b1;
                    else                cs_cnt   <= cs_cnt + 2'd1;
                end
            end else if (cs_fall) begin
                bit_cnt <= '0;
            end else if (bit_sample) begin
                shreg   <= byte_val[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (byte_done) begin
                unique case (state)
                    CMD:     is_read <= byte_val[0];
                    ADDR_HI: addr[15:8] <= byte_val;
                    ADDR_LO: begin
                        addr[7:0] <= byte_val;
                        load      <= 1'b1;
                    end
                    DATA: begin
                        addr <= addr + 16'd1;
                        load <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (we) begin
                wr_stb  <= 1'b1;
                wr_addr <= off[7:0];
                wr_data <= byte_val;
            end

            // no shift on the falling edge that closes a byte: bit 7 of the next byte is already loaded
            if (load)
                tx <= rd_val;
            else if (sclk_fall && state == DATA && bit_cnt != 3'd0)
                tx <= {tx[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            dbg_data <= 8'h00;
        end else begin
            if (we) mem[off[7:0]] <= byte_val;
            dbg_data <= (we && off[7:0] == dbg_addr) ? byte_val : mem[dbg_addr];
        end
    end

endmodule

// File: tb/tb_adau1761_spi_responder.sv
// Directed SPI frames against the ADAU1761 responder; writes, read bytes and sdo_oe windows
// are scoreboarded through queues and checked by independent monitors.
module tb_adau1761_spi_responder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       sdi = 1'b0;
    logic       sdo, sdo_oe, spi_mode, wr_stb, frame_err;
    logic [7:0] wr_addr, wr_data, dbg_data;
    logic [7:0] dbg_addr = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    int          oe_q [$];
    int          ferr_cnt = 0;

    adau1761_spi_responder dut (
        .clk(clk), .resetn(resetn), .sclk(sclk), .cs(cs), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .spi_mode(spi_mode),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err(frame_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // write monitor, plus same-cycle dbg readback of the committed offset
    logic [15:0] wexp;
    bit          pend = 1'b0;
    logic [7:0]  pend_data;
    always @(negedge clk) begin
        if (pend) begin
            check("dbg_bypass", dbg_data, pend_data);
            pend = 1'b0;
        end
        if (resetn && frame_err) ferr_cnt++;
        if (resetn && wr_stb) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", {wr_addr, wr_data}, 16'hxxxx === 16'h0 ? 0 : -1);
            end else begin
                wexp = wr_q.pop_front();
                check("wr_addr", wr_addr, wexp[15:8]);
                check("wr_data", wr_data, wexp[7:0]);
                if (dbg_addr == wexp[15:8]) begin
                    pend      = 1'b1;
                    pend_data = wexp[7:0];
                end
            end
        end
    end

    // read monitor: the controller samples sdo on sclk rising
    logic [7:0] rx = 8'h00;
    int         nb = 0;
    int         oe_cnt = 0;
    always @(posedge sclk) begin
        if (sdo_oe) begin
            rx = {rx[6:0], sdo};
            nb++;
            oe_cnt++;
            if (nb == 8) begin
                if (rd_q.size() == 0) check("rd_unexpected", rx, -1);
                else check("rd_byte", rx, rd_q.pop_front());
                nb = 0;
            end
        end
    end

    always @(posedge cs) begin
        if (resetn) begin
            if (oe_q.size() == 0) check("oe_unexpected", oe_cnt, -1);
            else check("oe_bits", oe_cnt, oe_q.pop_front());
            oe_cnt = 0;
            nb     = 0;
        end
    end

    task automatic spi(input logic [63:0] d, input int nbits, input bit start, input bit stop,
                       input int oe_bits);
        if (start) begin
            cs = 1'b0;
            repeat (8) @(negedge clk);
        end
        for (int i = 0; i < nbits; i++) begin
            sdi = d[63-i];
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
        if (stop) begin
            repeat (8) @(negedge clk);
            oe_q.push_back(oe_bits);
            cs = 1'b1;
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic dbg_check(input logic [7:0] a, input logic [7:0] exp);
        dbg_addr = a;
        repeat (2) @(negedge clk);
        check("dbg_data", dbg_data, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        check("rst_spi_mode", spi_mode, 0);
        check("rst_wr_stb", wr_stb, 0);
        check("rst_sdo", sdo, 0);
        check("rst_sdo_oe", sdo_oe, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_dbg", dbg_data, 0);
        resetn = 1'b1;
        repeat (8) @(negedge clk);

        // pre-mode traffic is discarded; the third cs rise latches SPI mode
        spi(64'h00_4000_01_00000000, 32, 1, 1, 0);
        check("mode_after_1", spi_mode, 0);
        spi(64'h01_4000_00_00000000, 32, 1, 1, 0);
        check("mode_after_2", spi_mode, 0);
        dbg_check(8'h00, 8'h00);
        spi(64'h0, 0, 1, 1, 0);
        check("mode_after_3", spi_mode, 1);

        wr_q.push_back(16'h00_01);
        spi(64'h00_4000_01_00000000, 32, 1, 1, 0);
        dbg_check(8'h00, 8'h01);

        wr_q.push_back(16'h23_F7);
        wr_q.push_back(16'h24_F7);
        wr_q.push_back(16'h25_F7);
        wr_q.push_back(16'h26_F7);
        spi(64'h00_4023_F7F7F7F7_00, 56, 1, 1, 0);
        dbg_check(8'h26, 8'hF7);

        wr_q.push_back(16'h0A_5B);
        spi(64'h00_400A_5B_00000000, 32, 1, 1, 0);
        rd_q.push_back(8'h5B);
        spi(64'h01_400A_00_00000000, 32, 1, 1, 8);

        // partial byte: 20 bits then cs rises
        spi(64'h00_4019_03_00000000, 20, 1, 1, 0);
        check("frame_err_cnt", ferr_cnt, 1);
        dbg_addr = 8'h19;
        wr_q.push_back(16'h19_03);
        spi(64'h00_4019_03_00000000, 32, 1, 1, 0);
        dbg_check(8'h19, 8'h03);

        spi(64'h00_3000_AA_00000000, 32, 1, 1, 0);
        rd_q.push_back(8'h00);
        spi(64'h01_3000_00_00000000, 32, 1, 1, 8);

        rd_q.push_back(8'hF7);
        rd_q.push_back(8'hF7);
        spi(64'h01_4025_0000_000000, 40, 1, 1, 16);

        // window edge: second byte of the burst lands at 0x4100, outside the map
        wr_q.push_back(16'hFF_11);
        spi(64'h00_40FF_1122_000000, 40, 1, 1, 0);
        dbg_check(8'hFF, 8'h11);

        // reset in the middle of a frame; the rest of that frame must be ignored
        spi(64'h00_4030_55_00000000, 12, 1, 0, 0);
        resetn = 1'b0;
        repeat (4) @(negedge clk);
        check("rst2_spi_mode", spi_mode, 0);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        spi(64'h0, 20, 0, 1, 0);
        dbg_check(8'h00, 8'h00);
        spi(64'h0, 0, 1, 1, 0);
        spi(64'h0, 0, 1, 1, 0);
        check("rst2_mode", spi_mode, 1);
        wr_q.push_back(16'h30_77);
        spi(64'h00_4030_77_00000000, 32, 1, 1, 0);
        dbg_check(8'h30, 8'h77);

        repeat (20) @(negedge clk);
        check("wr_q_empty", wr_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        check("oe_q_empty", oe_q.size(), 0);
        check("frame_err_total", ferr_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
